jk_flip_flop: RTL and testbench

//   Positive-edge-triggered JK flip-flop bank with asynchronous active-low clear.

---
 rtl/jk_flip_flop.sv | 57 +++++
 tb/tb_jk_flip_flop.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent positive-edge JK flip-flops with asynchronous active-low clear.
// Q1 is the registered state; Q2 is its complement, taken from the same register.
module jk_flip_flop #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RST_VALUE = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2
);

  logic             r_arm;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  // Release is re-timed to the falling edge, so a rising edge that coincides
  // with reset release can never update the state.
  always_ff @(negedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_arm <= 1'b0;
    end else begin
      r_arm <= 1'b1;
    end
  end

  // Per-bit JK truth table.
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({J[i], K[i]})
        2'b00:   w_q_next[i] = r_q[i];
        2'b01:   w_q_next[i] = 1'b0;
        2'b10:   w_q_next[i] = 1'b1;
        2'b11:   w_q_next[i] = ~r_q[i];
        default: w_q_next[i] = r_q[i];
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_q <= RST_VALUE;
    end else if (r_arm) begin
      r_q <= w_q_next;
    end else begin
      r_q <= r_q;
    end
  end

  assign Q1 = r_q;
  assign Q2 = ~r_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Randomised bench for jk_flip_flop (WIDTH=4) against a characteristic-equation model,
// plus literal expectations for the classic directed scenarios.
module tb_jk_flip_flop;

  localparam int              W   = 4;
  localparam logic [W-1:0]    RST = 4'b0000;

  logic         CLK   = 1'b0;
  logic         RST_n = 1'b0;
  logic [W-1:0] J     = 4'b0000;
  logic [W-1:0] K     = 4'b0000;
  logic [W-1:0] Q1;
  logic [W-1:0] Q2;

  logic [W-1:0] m_q       = RST;
  time          t_release = 64'hFFFF_FFFF_FFFF_FFFF;
  logic         chk_en    = 1'b0;
  int           n_vec     = 0;
  int           n_err     = 0;

  jk_flip_flop #(.WIDTH(W), .RST_VALUE(RST)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .J    (J),
    .K    (K),
    .Q1   (Q1),
    .Q2   (Q2)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: Q+ = J&~Q | ~K&Q, except the edge coinciding with reset release.
  always @(posedge CLK) begin
    if (RST_n == 1'b0) begin
      m_q = RST;
    end else if (t_release != $time) begin
      m_q = (J & ~m_q) | (~K & m_q);
    end
  end

  always @(negedge RST_n) m_q = RST;

  // Per-cycle comparison, away from the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("q1_model", Q1, m_q);
      check("q2_model", Q2, ~m_q);
      check("q2_compl", Q2, ~Q1);
    end
  end

  // Called at negedge+1; drives J/K, waits one rising edge, checks at next negedge+1.
  task automatic apply(input logic [W-1:0] j, input logic [W-1:0] k,
                       input logic [W-1:0] exp, input string name);
    J = j;
    K = k;
    @(negedge CLK);
    #1;
    check({name, "_q1"}, Q1, exp);
    check({name, "_q2"}, Q2, ~exp);
    check({name, "_mdl"}, m_q, exp);
  endtask

  task automatic release_reset();
    t_release = $time;
    RST_n     = 1'b1;
  endtask

  initial begin
    // Reset state
    @(negedge CLK);
    #1;
    check("rst_q1", Q1, 4'b0000);
    check("rst_q2", Q2, 4'b1111);
    chk_en = 1'b1;
    @(posedge CLK);
    #2;
    release_reset();
    @(negedge CLK);
    #1;

    apply(4'b0000, 4'b1111, 4'b0000, "clear");
    apply(4'b1111, 4'b0000, 4'b1111, "set");
    // J/K wiggle while CLK is low
    J = 4'b0000;
    K = 4'b1111;
    #2;
    check("lowchg_q1", Q1, 4'b1111);
    apply(4'b0000, 4'b0000, 4'b1111, "hold");

    // Async reset mid-cycle, then J=K=1 during reset
    RST_n = 1'b0;
    #1;
    check("async_q1", Q1, 4'b0000);
    check("async_q2", Q2, 4'b1111);
    J = 4'b1111;
    K = 4'b1111;
    @(negedge CLK);
    #1;
    check("inrst_q1", Q1, 4'b0000);

    // Release coincident with a rising edge, J=K=1
    #4;
    release_reset();
    @(negedge CLK);
    #1;
    check("coinc_q1", Q1, 4'b0000);
    check("coinc_mdl", m_q, 4'b0000);
    apply(4'b1111, 4'b1111, 4'b1111, "tog1");
    apply(4'b1111, 4'b1111, 4'b0000, "tog2");

    // Independent per-bit behaviour
    apply(4'b0101, 4'b0011, 4'b0101, "bits1");
    apply(4'b1100, 4'b1010, 4'b1101, "bits2");

    // Randomised phase
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        RST_n = 1'b0;
        #1;
        check("rnd_async_q1", Q1, RST);
        J = W'($urandom);
        K = W'($urandom);
        @(negedge CLK);
        #1;
        J = W'($urandom);
        K = W'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          #4;
          release_reset();
        end else begin
          #6;
          release_reset();
        end
        @(negedge CLK);
        #1;
      end else begin
        J = W'($urandom);
        K = W'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          #2;
          J = W'($urandom);
          K = W'($urandom);
        end
        @(negedge CLK);
        #1;
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
